// File: rtl/lcd_up_pkg.sv
// Shared constants for the LCD up_ register interface: register map,
// STATUS bit positions and command FSM encoding.
package lcd_up_pkg;

    localparam int unsigned ADDR_CTRL   = 0;
    localparam int unsigned ADDR_STATUS = 1;
    localparam int unsigned ADDR_XY     = 2;
    localparam int unsigned ADDR_DIM    = 3;
    localparam int unsigned ADDR_COLOR  = 4;
    localparam int unsigned ADDR_COUNT  = 5;

    localparam int unsigned CTRL_START_BIT    = 0;
    localparam int unsigned STAT_INIT_DONE    = 3;
    localparam int unsigned STAT_PIX_DONE     = 4;
    localparam int unsigned STAT_BUSY         = 5;
    localparam int unsigned STAT_ERR          = 6;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

endpackage

// File: rtl/lcd_up_regif.sv
// up_ bus register block that issues single-pixel draw commands to an
// external pixel core and tracks completion, errors and a pixel count.
module lcd_up_regif
    import lcd_up_pkg::*;
#(
    parameter int          ADDRESS_WIDTH = 12,
    parameter logic [15:0] LCD_W_P       = 16'd128,
    parameter logic [15:0] LCD_H_P       = 16'd128
) (
    input  logic                     up_clk,
    input  logic                     up_rstn,
    input  logic                     up_wreq,
    input  logic [ADDRESS_WIDTH-1:0] up_waddr,
    input  logic [31:0]              up_wdata,
    output logic                     up_wack,
    input  logic                     up_rreq,
    input  logic [ADDRESS_WIDTH-1:0] up_raddr,
    output logic [31:0]              up_rdata,
    output logic                     up_rack,
    input  logic                     init_done,
    output logic                     px_start,
    output logic [15:0]              px_x,
    output logic [15:0]              px_y,
    output logic [15:0]              px_color,
    input  logic                     px_done
);

    logic [1:0]  state;
    logic [15:0] x_reg;
    logic [15:0] y_reg;
    logic [15:0] color_reg;
    logic        pix_done_r;
    logic        err_r;
    logic [31:0] count_r;

    logic        wr_en;
    logic        start_wr;
    logic        busy;
    logic        xy_ok;
    logic [31:0] status_word;
    logic [31:0] rd_mux;

    // Handshake: a held request is accepted once, on the edge that raises the ack;
    // the ack cycle itself never accepts, so the initiator has one cycle to drop req.
    assign wr_en    = up_wreq & ~up_wack;
    assign start_wr = wr_en && (up_waddr == ADDRESS_WIDTH'(ADDR_CTRL))
                      && up_wdata[CTRL_START_BIT];
    assign busy     = (state != ST_IDLE);
    assign xy_ok    = (x_reg < LCD_W_P) && (y_reg < LCD_H_P);

    always_comb begin
        status_word                 = 32'd0;
        status_word[STAT_INIT_DONE] = init_done;
        status_word[STAT_PIX_DONE]  = pix_done_r;
        status_word[STAT_BUSY]      = busy;
        status_word[STAT_ERR]       = err_r;
    end

    always_comb begin
        rd_mux = 32'd0;
        case (up_raddr)
            ADDRESS_WIDTH'(ADDR_STATUS): rd_mux = status_word;
            ADDRESS_WIDTH'(ADDR_XY):     rd_mux = {x_reg, y_reg};
            ADDRESS_WIDTH'(ADDR_DIM):    rd_mux = {LCD_W_P, LCD_H_P};
            ADDRESS_WIDTH'(ADDR_COLOR):  rd_mux = {16'd0, color_reg};
            ADDRESS_WIDTH'(ADDR_COUNT):  rd_mux = count_r;
            default:                     rd_mux = 32'd0;
        endcase
    end

    always_ff @(posedge up_clk or negedge up_rstn) begin
        if (!up_rstn) begin
            up_wack   <= 1'b0;
            up_rack   <= 1'b0;
            up_rdata  <= 32'd0;
            x_reg     <= 16'd0;
            y_reg     <= 16'd0;
            color_reg <= 16'd0;
        end else begin
            up_wack <= up_wreq & ~up_wack;
            up_rack <= up_rreq & ~up_rack;
            // Refreshed every cycle rreq is high so STATUS can be polled without re-request.
            if (up_rreq) begin
                up_rdata <= rd_mux;
            end
            if (wr_en && (up_waddr == ADDRESS_WIDTH'(ADDR_XY))) begin
                x_reg <= up_wdata[31:16];
                y_reg <= up_wdata[15:0];
            end
            if (wr_en && (up_waddr == ADDRESS_WIDTH'(ADDR_COLOR))) begin
                color_reg <= up_wdata[15:0];
            end
        end
    end

    always_ff @(posedge up_clk or negedge up_rstn) begin
        if (!up_rstn) begin
            state      <= ST_IDLE;
            px_start   <= 1'b0;
            px_x       <= 16'd0;
            px_y       <= 16'd0;
            px_color   <= 16'd0;
            pix_done_r <= 1'b0;
            err_r      <= 1'b0;
            count_r    <= 32'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    px_x     <= x_reg;
                    px_y     <= y_reg;
                    px_color <= color_reg;
                    if (start_wr) begin
                        if (init_done && xy_ok) begin
                            state      <= ST_ISSUE;
                            px_start   <= 1'b1;
                            pix_done_r <= 1'b0;
                            err_r      <= 1'b0;
                        end else begin
                            // Rejected command still completes so pollers see PIX_DONE.
                            err_r      <= 1'b1;
                            pix_done_r <= 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    px_start <= 1'b0;
                    state    <= ST_WAIT;
                    if (start_wr) begin
                        err_r <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (px_done) begin
                        state      <= ST_IDLE;
                        pix_done_r <= 1'b1;
                        count_r    <= count_r + 32'd1;
                    end
                    if (start_wr) begin
                        err_r <= 1'b1;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    px_start <= 1'b0;
                end
            endcase
        end
    end

endmodule
